// File: rtl/csr_access_arbiter_if.sv
// CSR access arbiter bus bundle: pipeline request/commit, debug abstract
// access, and the single CSR register-file port.
// The arbiter connects through the slave modport; the environment (issue and
// commit stages, debug module, CSR file) connects through the master modport.
interface csr_access_arbiter_if #(
    parameter int XLEN = 64
);
    // pipeline side
    logic            flush_i;
    logic            pipe_valid_i;
    logic            pipe_ready_o;
    logic [11:0]     pipe_addr_i;
    logic [XLEN-1:0] pipe_wdata_i;
    logic            pipe_commit_i;
    logic [XLEN-1:0] pipe_rdata_o;

    // debug module side
    logic            dbg_req_i;
    logic            dbg_we_i;
    logic [11:0]     dbg_addr_i;
    logic [XLEN-1:0] dbg_wdata_i;
    logic            dbg_gnt_o;
    logic            dbg_rvalid_o;
    logic [XLEN-1:0] dbg_rdata_o;

    // CSR register file side
    logic            csr_valid_o;
    logic [11:0]     csr_addr_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic            csr_we_o;
    logic [XLEN-1:0] csr_rdata_i;

    logic            timeout_o;

    modport slave (
        input  flush_i, pipe_valid_i, pipe_addr_i, pipe_wdata_i, pipe_commit_i,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  csr_rdata_i,
        output pipe_ready_o, pipe_rdata_o,
        output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        output csr_valid_o, csr_addr_o, csr_wdata_o, csr_we_o,
        output timeout_o
    );

    modport master (
        output flush_i, pipe_valid_i, pipe_addr_i, pipe_wdata_i, pipe_commit_i,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output csr_rdata_i,
        input  pipe_ready_o, pipe_rdata_o,
        input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        input  csr_valid_o, csr_addr_o, csr_wdata_o, csr_we_o,
        input  timeout_o
    );
endinterface

// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: shares the single CSR register-file port between the
// issue pipeline (speculative ops written only on commit) and the debug
// module (fixed-latency abstract reads/writes). One op outstanding at a time.
//
// Build option: define CSR_ARB_RR_EN for round-robin arbitration on ties;
// otherwise debug has fixed priority over the pipeline.
//
// csr_* outputs decode only from registered state (plus pipe_commit_i for the
// same-cycle commit write), so request inputs never reach the CSR port
// combinationally.
module csr_access_arbiter #(
    parameter int XLEN           = 64,
    parameter int COMMIT_TIMEOUT = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    csr_access_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PIPE_HOLD  = 2'd1,
        DBG_ACCESS = 2'd2,
        DBG_RESP   = 2'd3
    } state_t;

    localparam int CW = $clog2(COMMIT_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(COMMIT_TIMEOUT);

    state_t          state_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            we_q;
    logic [XLEN-1:0] resp_q;
    logic [CW-1:0]   hold_cnt_q;

    logic in_idle, in_hold, in_access, in_resp;
    logic dbg_win, pipe_fire, dbg_fire;

    assign in_idle   = (state_q == IDLE);
    assign in_hold   = (state_q == PIPE_HOLD);
    assign in_access = (state_q == DBG_ACCESS);
    assign in_resp   = (state_q == DBG_RESP);

`ifdef CSR_ARB_RR_EN
    // 1 = debug was granted last; reset value lets the pipeline win the first tie
    logic last_dbg_q;
    logic pipe_req;

    // A flushed pipeline request cannot be accepted, so it does not contend
    assign pipe_req = bus.pipe_valid_i & ~bus.flush_i;
    assign dbg_win  = bus.dbg_req_i & (~pipe_req | ~last_dbg_q);
`else
    assign dbg_win  = bus.dbg_req_i;
`endif

    // No handshakes are offered while reset is asserted
    assign pipe_fire = in_idle & ~rst_i & ~bus.flush_i & ~dbg_win & bus.pipe_valid_i;
    assign dbg_fire  = in_idle & ~rst_i & dbg_win;

    // Arbitration state, operand capture, debug response capture and commit timer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            resp_q     <= '0;
            hold_cnt_q <= '0;
`ifdef CSR_ARB_RR_EN
            last_dbg_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (dbg_fire) begin
                        state_q <= DBG_ACCESS;
                        we_q    <= bus.dbg_we_i;
                        addr_q  <= bus.dbg_addr_i;
                        wdata_q <= bus.dbg_wdata_i;
`ifdef CSR_ARB_RR_EN
                        last_dbg_q <= 1'b1;
`endif
                    end else if (pipe_fire) begin
                        state_q    <= PIPE_HOLD;
                        we_q       <= 1'b0;
                        addr_q     <= bus.pipe_addr_i;
                        wdata_q    <= bus.pipe_wdata_i;
                        hold_cnt_q <= '0;
`ifdef CSR_ARB_RR_EN
                        last_dbg_q <= 1'b0;
`endif
                    end
                end
                PIPE_HOLD: begin
                    // Commit and flush together still commits: the write is
                    // issued combinationally this cycle either way
                    if (bus.pipe_commit_i || bus.flush_i) begin
                        state_q    <= IDLE;
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q != CNT_MAX) begin
                        hold_cnt_q <= hold_cnt_q + CW'(1);
                    end
                end
                DBG_ACCESS: begin
                    resp_q  <= bus.csr_rdata_i;
                    state_q <= DBG_RESP;
                end
                DBG_RESP: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs
    assign bus.pipe_ready_o = in_idle & ~rst_i & ~bus.flush_i & ~dbg_win;
    assign bus.dbg_gnt_o    = dbg_fire;

    // CSR port: driven only while an op owns it
    assign bus.csr_valid_o = in_hold | in_access;
    assign bus.csr_addr_o  = bus.csr_valid_o ? addr_q  : 12'd0;
    assign bus.csr_wdata_o = bus.csr_valid_o ? wdata_q : '0;
    assign bus.csr_we_o    = ~rst_i & ((in_hold & bus.pipe_commit_i) | (in_access & we_q));

    // Read-data returns
    assign bus.pipe_rdata_o = in_hold ? bus.csr_rdata_i : '0;
    assign bus.dbg_rvalid_o = in_resp;
    assign bus.dbg_rdata_o  = in_resp ? resp_q : '0;

    // Stuck-commit indicator; the held op stays in place
    assign bus.timeout_o = in_hold & (hold_cnt_q >= CNT_MAX);

endmodule

// File: doc/csr_access_arbiter.md
# csr_access_arbiter

Arbitrates the single CSR access path between the issue pipeline (speculative CSR instructions awaiting commit) and the debug module (abstract-command CSR reads/writes). Sits between the issue/commit stages and the CSR register file, alongside the CSR buffer. Holds at most one outstanding operation. Pipeline writes fire only on commit. Debug accesses complete autonomously in a fixed number of cycles.

## Interface
- XLEN, 64, CSR data width
- COMMIT_TIMEOUT, 64, cycles in PIPE_HOLD before timeout_o asserts (≥2)
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  pipeline flush; discards a held pipeline op
- pipe_valid_i  in  1  pipeline CSR op request
- pipe_ready_o  out  1  pipeline request accepted this cycle when valid&ready
- pipe_addr_i  in  12  pipeline CSR address
- pipe_wdata_i  in  XLEN  pipeline write data
- pipe_commit_i  in  1  commit stage retires the held op
- pipe_rdata_o  out  XLEN  read data for held op (csr_rdata_i passthrough in PIPE_HOLD, else 0)
- dbg_req_i  in  1  debug access request, held until grant
- dbg_we_i  in  1  debug write (1) / read (0)
- dbg_addr_i  in  12  debug CSR address
- dbg_wdata_i  in  XLEN  debug write data
- dbg_gnt_o  out  1  one-cycle grant; request fields captured this cycle
- dbg_rvalid_o  out  1  one-cycle response strobe
- dbg_rdata_o  out  XLEN  response data, valid with dbg_rvalid_o
- csr_valid_o  out  1  address/data to CSR file valid
- csr_addr_o  out  12  CSR address
- csr_wdata_o  out  XLEN  CSR write data
- csr_we_o  out  1  write strobe to CSR file (single cycle)
- csr_rdata_i  in  XLEN  combinational CSR read data for csr_addr_o
- timeout_o  out  1  held pipeline op exceeded COMMIT_TIMEOUT

## Operation
- States: IDLE, PIPE_HOLD, DBG_ACCESS, DBG_RESP.
- IDLE: arbitration between pipe_valid_i and dbg_req_i. Default is fixed priority with debug over pipeline. pipe_ready_o = (state==IDLE) & ~flush_i & ~dbg_win. dbg_gnt_o = (state==IDLE) & dbg_win.
- Pipe handshake: capture addr/wdata and go to PIPE_HOLD.
- Debug grant: capture we/addr/wdata and go to DBG_ACCESS.
- PIPE_HOLD: csr_valid_o=1, csr_addr_o=held addr, csr_wdata_o=held data.
  - pipe_commit_i: csr_we_o=1 in the same cycle, then go to IDLE.
  - flush_i without commit: go to IDLE with no write.
  - commit and flush in the same cycle: commit wins (write performed).
- DBG_ACCESS: csr_valid_o=1, csr_we_o=held we. Capture csr_rdata_i into the response register, then go to DBG_RESP.
- DBG_RESP: dbg_rvalid_o=1, dbg_rdata_o=captured data, then go to IDLE. flush_i has no effect in either debug state.
- Timeout: a counter clears on entry to PIPE_HOLD and increments each PIPE_HOLD cycle, saturating. timeout_o=1 while count ≥ COMMIT_TIMEOUT and state==PIPE_HOLD. Leaving PIPE_HOLD clears it. The op is not aborted.
- csr_addr_o, csr_wdata_o and csr_we_o are 0 in IDLE and DBG_RESP.

## Timing
- Reset: state IDLE, all outputs 0, capture registers and counter 0, last-grant = debug. Reset mid-operation drops the op with no write and no response.
- Pipeline op accepted at cycle N: csr_valid_o from N+1. Commit at cycle M≥N+1 gives csr_we_o at M. pipe_ready_o can be 1 again at M+1.
- Debug grant at N: DBG_ACCESS at N+1 (write occurs here), dbg_rvalid_o at N+2, IDLE at N+3.
- Back-to-back debug: the next grant is earliest at N+3.
- No combinational path from pipe_valid_i or dbg_req_i to csr_* outputs.

## Configuration
- CSR_ARB_RR_EN defined: round-robin arbitration.
  - When both request in IDLE, grant the requester not granted last.
  - The last-grant register updates on each grant; its reset value is debug, so the pipeline wins the first tie.
  - A single requester is always granted.
- CSR_ARB_RR_EN undefined: fixed priority, debug always wins ties. The last-grant register is absent.

## Test plan
- Pipe op: addr 0x300, wdata 0xA, commit 3 cycles after accept → csr_valid_o for 3 cycles, csr_we_o single pulse with addr 0x300/data 0xA, pipe_ready_o=1 next cycle.
- Flush while held: accept addr 0x341, flush_i 2 cycles later → no csr_we_o, state IDLE next cycle. Repeat with commit and flush in the same cycle → csr_we_o=1.
- Debug read: dbg_req_i, dbg_we_i=0, addr 0xF14, csr_rdata_i=0x5 → dbg_gnt_o at N, csr_we_o=0, dbg_rvalid_o with 0x5 at N+2.
- Simultaneous pipe_valid_i and dbg_req_i, twice in a row.
  - Fixed priority: debug granted both times.
  - With CSR_ARB_RR_EN: pipe granted first, debug second.
- Timeout with COMMIT_TIMEOUT=4: hold without commit → timeout_o rises after 4 PIPE_HOLD cycles and stays high. Commit then clears it with the write performed.
- Reset asserted in DBG_ACCESS → no dbg_rvalid_o, all outputs 0 next cycle.
